// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: captures an NxN tile from the PE chain, rescales and
// saturates each element on capture, then streams the tile out row-major over valid/ready.
module systolic_result_drain #(
    parameter int N      = 4,
    parameter int DATA_W = 16,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     OutputSign,
    input  logic [$clog2(N)-1:0]     row_out,
    input  logic signed [DATA_W-1:0] pe_data,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [$clog2(N)-1:0]     out_row,
    output logic [$clog2(N)-1:0]     out_col,
    output logic                     out_last,
    output logic                     busy,
    output logic                     tile_done,
    output logic                     sat_err,
    output logic                     proto_err,
    output logic                     overrun_err,
    input  logic                     err_clr
);

    localparam int IW = $clog2(N);
    localparam int CW = 2 * IW;
    localparam int NE = N * N;

    localparam logic [IW-1:0] COL_LAST = IW'(N - 1);
    localparam logic [CW-1:0] IDX_LAST = CW'(NE - 1);

    localparam logic signed [DATA_W-1:0] SAT_MAX = DATA_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [DATA_W-1:0] SAT_MIN = DATA_W'(-(2 ** (OUT_W - 1)));

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_DRAIN   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [IW-1:0] col_cnt_q, col_cnt_d;
    logic [CW-1:0] cap_cnt_q, cap_cnt_d;
    logic [IW-1:0] row_lat_q, row_lat_d;
    logic [CW-1:0] rd_idx_q,  rd_idx_d;
    logic          sat_err_q, sat_err_d;
    logic          proto_err_q, proto_err_d;
    logic          overrun_err_q, overrun_err_d;

    logic signed [OUT_W-1:0] tile_q [NE];

    logic                    cap_fire;
    logic                    accept;
    logic                    last_acc;
    logic [IW-1:0]           wr_row;
    logic [CW-1:0]           wr_addr;
    logic [OUT_W:0]          scaled;
    logic signed [OUT_W-1:0] wr_data;
    logic                    wr_sat;
    logic                    proto_set;
    logic                    overrun_set;

    // Returns {saturated, value}: arithmetic shift then clamp to the signed OUT_W range.
    function automatic logic [OUT_W:0] sat_scale(input logic signed [DATA_W-1:0] x);
        logic signed [DATA_W-1:0] v;
        v = x >>> SHIFT;
        if (v > SAT_MAX) begin
            return {1'b1, SAT_MAX[OUT_W-1:0]};
        end else if (v < SAT_MIN) begin
            return {1'b1, SAT_MIN[OUT_W-1:0]};
        end else begin
            return {1'b0, v[OUT_W-1:0]};
        end
    endfunction

    assign cap_fire = OutputSign && ((state_q == S_IDLE) || (state_q == S_CAPTURE));
    assign accept   = (state_q == S_DRAIN) && out_ready;
    assign last_acc = accept && (rd_idx_q == IDX_LAST);

    // A row's index is latched on its first element; later elements of the row reuse it.
    assign wr_row  = (col_cnt_q == '0) ? row_out : row_lat_q;
    assign wr_addr = {wr_row, col_cnt_q};
    assign scaled  = sat_scale(pe_data);
    assign wr_sat  = scaled[OUT_W];
    assign wr_data = scaled[OUT_W-1:0];

    assign proto_set =
        ((state_q == S_IDLE) && OutputSign && (row_out != '0)) ||
        ((state_q == S_CAPTURE) && OutputSign && (col_cnt_q != '0) && (row_out != row_lat_q)) ||
        ((state_q == S_CAPTURE) && !OutputSign && (cap_cnt_q != '0));
    assign overrun_set = (state_q == S_DRAIN) && OutputSign;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (OutputSign) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (OutputSign && (cap_cnt_q == IDX_LAST)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_acc) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == S_DRAIN);
        busy      = (state_q != S_IDLE);
        tile_done = last_acc;
        out_data  = '0;
        out_row   = '0;
        out_col   = '0;
        out_last  = 1'b0;
        if (state_q == S_DRAIN) begin
            out_data = tile_q[rd_idx_q];
            out_row  = rd_idx_q[CW-1:IW];
            out_col  = rd_idx_q[IW-1:0];
            out_last = (rd_idx_q == IDX_LAST);
        end
    end

    always_comb begin
        col_cnt_d = col_cnt_q;
        cap_cnt_d = cap_cnt_q;
        row_lat_d = row_lat_q;
        rd_idx_d  = rd_idx_q;
        if (cap_fire) begin
            col_cnt_d = (col_cnt_q == COL_LAST) ? '0 : col_cnt_q + 1'b1;
            cap_cnt_d = (cap_cnt_q == IDX_LAST) ? '0 : cap_cnt_q + 1'b1;
            if (col_cnt_q == '0) begin
                row_lat_d = row_out;
            end
        end
        if (accept) begin
            rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + 1'b1;
        end
    end

    // Sticky flags: a set event in the same cycle as err_clr takes priority.
    always_comb begin
        sat_err_d     = (cap_fire && wr_sat) || (sat_err_q && !err_clr);
        proto_err_d   = proto_set || (proto_err_q && !err_clr);
        overrun_err_d = overrun_set || (overrun_err_q && !err_clr);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            col_cnt_q     <= '0;
            cap_cnt_q     <= '0;
            row_lat_q     <= '0;
            rd_idx_q      <= '0;
            sat_err_q     <= 1'b0;
            proto_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            col_cnt_q     <= col_cnt_d;
            cap_cnt_q     <= cap_cnt_d;
            row_lat_q     <= row_lat_d;
            rd_idx_q      <= rd_idx_d;
            sat_err_q     <= sat_err_d;
            proto_err_q   <= proto_err_d;
            overrun_err_q <= overrun_err_d;
        end
    end

    // Tile storage holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (cap_fire) begin
            tile_q[wr_addr] <= wr_data;
        end
    end

    assign sat_err     = sat_err_q;
    assign proto_err   = proto_err_q;
    assign overrun_err = overrun_err_q;

endmodule
